cache_control: RTL

- Finite state machine for the direct-mapped, write-back LC-3b data cache. Sits between the CPU memory port and physical memory.
- Controls the cache datapath:
  - tag, valid and dirty arrays;
  - data array whose write data is either the merged store line (CPU word written into the current line) or the 128-bit line returned by physical memory.
- Sequences hit, writeback and allocate.
- Keeps saturating hit, miss and writeback counters for performance debug.

---
 rtl/cache_control.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cache_control.sv
// -----------------------------------------------------------------------------
// cache_control
//   Control FSM for the direct-mapped, write-back LC-3b data cache. It sits
//   between the CPU memory port and physical memory and sequences hit,
//   writeback and allocate. It also keeps saturating performance counters.
//
// Ports
//   clk, reset           : clock; asynchronous active-high reset
//   mem_read, mem_write  : CPU request (a write wins if both are set)
//   mem_resp             : CPU request complete (combinational, one cycle)
//   hit, dirty           : datapath status for the current index
//   pmem_resp            : physical memory transfer complete
//   pmem_read/pmem_write : physical memory line strobes
//   pmem_addr_sel        : 0 = CPU address, 1 = stored tag/index line address
//   datain_sel           : 0 = merged store line, 1 = pmem_rdata
//   load_data/tag/valid/dirty, dirty_in : array write controls
//   cnt_clr              : synchronous clear of all counters
//   hit_cnt, miss_cnt, wb_cnt : saturating performance counters
// -----------------------------------------------------------------------------
module cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  input  logic                 hit,
  input  logic                 dirty,
  input  logic                 pmem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic                 pmem_addr_sel,
  output logic                 datain_sel,
  output logic                 load_data,
  output logic                 load_tag,
  output logic                 load_valid,
  output logic                 load_dirty,
  output logic                 dirty_in,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic [CNT_WIDTH-1:0] wb_cnt
);

  localparam logic [1:0] S_CHECK     = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_ALLOCATE  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  logic req_s;
  logic hit_inc_s, miss_inc_s, wb_inc_s;
  logic mem_resp_s, pmem_read_s, pmem_write_s, pmem_addr_sel_s;
  logic datain_sel_s, load_data_s, load_tag_s, load_valid_s;
  logic load_dirty_s, dirty_in_s;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v,
    input logic                 en
  );
    if (en && (v != {CNT_WIDTH{1'b1}})) begin
      sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      sat_inc = v;
    end
  endfunction

  assign req_s = mem_read | mem_write;

  // Next-state and raw control decode.
  always_comb begin
    state_d         = state_q;
    hit_inc_s       = 1'b0;
    miss_inc_s      = 1'b0;
    wb_inc_s        = 1'b0;
    mem_resp_s      = 1'b0;
    pmem_read_s     = 1'b0;
    pmem_write_s    = 1'b0;
    pmem_addr_sel_s = 1'b0;
    datain_sel_s    = 1'b0;
    load_data_s     = 1'b0;
    load_tag_s      = 1'b0;
    load_valid_s    = 1'b0;
    load_dirty_s    = 1'b0;
    dirty_in_s      = 1'b0;
    case (state_q)
      S_CHECK: begin
        if (req_s && hit) begin
          hit_inc_s  = 1'b1;
          mem_resp_s = 1'b1;
          // mem_write takes priority when both request lines are set.
          if (mem_write) begin
            load_data_s  = 1'b1;
            load_dirty_s = 1'b1;
            dirty_in_s   = 1'b1;
          end else begin
            load_data_s  = 1'b0;
          end
        end else if (req_s) begin
          miss_inc_s = 1'b1;
          if (dirty) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_ALLOCATE;
          end
        end else begin
          state_d = S_CHECK;
        end
      end
      S_WRITEBACK: begin
        pmem_write_s    = 1'b1;
        pmem_addr_sel_s = 1'b1;
        if (pmem_resp) begin
          wb_inc_s = 1'b1;
          state_d  = S_ALLOCATE;
        end else begin
          state_d  = S_WRITEBACK;
        end
      end
      S_ALLOCATE: begin
        pmem_read_s = 1'b1;
        // The fill happens in the same cycle memory returns the line.
        if (pmem_resp) begin
          datain_sel_s = 1'b1;
          load_data_s  = 1'b1;
          load_tag_s   = 1'b1;
          load_valid_s = 1'b1;
          load_dirty_s = 1'b1;
          state_d      = S_CHECK;
        end else begin
          state_d      = S_ALLOCATE;
        end
      end
      default: begin
        state_d = S_CHECK;
      end
    endcase
  end

  // Controls are forced low for as long as reset is asserted.
  assign mem_resp      = mem_resp_s      & ~reset;
  assign pmem_read     = pmem_read_s     & ~reset;
  assign pmem_write    = pmem_write_s    & ~reset;
  assign pmem_addr_sel = pmem_addr_sel_s & ~reset;
  assign datain_sel    = datain_sel_s    & ~reset;
  assign load_data     = load_data_s     & ~reset;
  assign load_tag      = load_tag_s      & ~reset;
  assign load_valid    = load_valid_s    & ~reset;
  assign load_dirty    = load_dirty_s    & ~reset;
  assign dirty_in      = dirty_in_s      & ~reset;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_CHECK;
    end else begin
      state_q <= state_d;
    end
  end

  // Performance counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= {CNT_WIDTH{1'b0}};
      miss_cnt_q <= {CNT_WIDTH{1'b0}};
      wb_cnt_q   <= {CNT_WIDTH{1'b0}};
    end else if (cnt_clr) begin
      hit_cnt_q  <= {CNT_WIDTH{1'b0}};
      miss_cnt_q <= {CNT_WIDTH{1'b0}};
      wb_cnt_q   <= {CNT_WIDTH{1'b0}};
    end else begin
      hit_cnt_q  <= sat_inc(hit_cnt_q, hit_inc_s);
      miss_cnt_q <= sat_inc(miss_cnt_q, miss_inc_s);
      wb_cnt_q   <= sat_inc(wb_cnt_q, wb_inc_s);
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;

endmodule
